// File: rtl/s2p_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : s2p_pkg                                                   |
// | Purpose  : Shared state type and default framing constants for the  |
// |            serial-to-parallel deframer and its serializer partner.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package s2p_pkg;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int unsigned      c_WIDTH       = 16;
  localparam logic [15:0]      c_SYNC_WORD   = 16'hCCCC;
  localparam int unsigned      c_FRAME_WORDS = 4;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/s2p_deframer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: s2p_deframer_if                                           |
// | Purpose  : Valid/ready word output of the deframer, with a           |
// |            start-of-frame tag travelling alongside the data.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface s2p_deframer_if
  import s2p_pkg::*;
#(
  parameter int unsigned WIDTH = c_WIDTH
);

  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_sof;
  logic             i_ready;

  // Producer side: the deframer drives the word and samples ready.
  modport master (output o_data, output o_valid, output o_sof, input i_ready);

  // Consumer side: receives the word and drives ready.
  modport slave  (input o_data, input o_valid, input o_sof, output i_ready);

endinterface
`default_nettype wire

// File: rtl/s2p_shift_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s2p_shift_cnt                                             |
// | Purpose  : Serial shift register plus the hunt fill counter and the  |
// |            in-word bit counter; flags the last bit of each word.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module s2p_shift_cnt
  import s2p_pkg::*;
#(
  parameter int unsigned WIDTH = c_WIDTH
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_enable,
  input  wire logic             i_bit,
  input  wire logic             i_resync,
  input  wire logic             i_locked,
  output logic [WIDTH-1:0]      o_sr_next,
  output logic                  o_fill_ok,
  output logic                  o_word_done
);

  localparam int unsigned             c_FILL_W   = cnt_width(WIDTH + 1);
  localparam int unsigned             c_BIT_W    = cnt_width(WIDTH);
  localparam logic [c_FILL_W-1:0]     c_FILL_MAX = c_FILL_W'(WIDTH);
  localparam logic [c_FILL_W-1:0]     c_FILL_OK  = c_FILL_W'(WIDTH - 1);
  localparam logic [c_BIT_W-1:0]      c_BIT_LAST = c_BIT_W'(WIDTH - 1);

  logic [WIDTH-1:0]    r_sr;
  logic [c_FILL_W-1:0] r_fill;
  logic [c_BIT_W-1:0]  r_bit_cnt;

  assign o_sr_next   = {r_sr[WIDTH-2:0], i_bit};
  // Fill already at WIDTH-1 means the incoming bit completes a full window.
  assign o_fill_ok   = (r_fill >= c_FILL_OK);
  assign o_word_done = i_locked & i_enable & (r_bit_cnt == c_BIT_LAST);

  // Shift in qualified bits; a bit arriving with resync is thrown away.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= '0;
    end else if (i_enable && !i_resync) begin
      r_sr <= o_sr_next;
    end
  end

  // Count bits seen while hunting, saturating once a full window exists.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill <= '0;
    end else if (i_resync || i_locked) begin
      r_fill <= '0;
    end else if (i_enable && (r_fill != c_FILL_MAX)) begin
      r_fill <= r_fill + 1'b1;
    end
  end

  // Track bit position inside the current payload word while locked.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
    end else if (i_resync || !i_locked) begin
      r_bit_cnt <= '0;
    end else if (i_enable) begin
      r_bit_cnt <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/s2p_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : s2p_deframer                                              |
// | Purpose  : Hunts for the sync marker in a serial stream, assembles   |
// |            the following payload words MSB first and hands them out  |
// |            on a valid/ready port with a sticky overflow flag.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module s2p_deframer
  import s2p_pkg::*;
#(
  parameter int unsigned       WIDTH       = c_WIDTH,
  parameter logic [WIDTH-1:0]  SYNC_WORD   = c_SYNC_WORD,
  parameter int unsigned       FRAME_WORDS = c_FRAME_WORDS
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst_n,
  input  wire logic             i_S2P,
  input  wire logic             i_enable,
  input  wire logic             i_resync,
  input  wire logic             i_clr_ovf,
  s2p_deframer_if.master        bus,
  output logic                  o_locked,
  output logic                  o_overflow
);

  localparam logic [7:0] c_LAST_WORD = 8'(FRAME_WORDS - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_word_cnt;
  logic [7:0]       w_word_cnt_next;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_fill_ok;
  logic             w_word_done;
  logic             w_load;
  logic             w_ovf_set;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_sof;
  logic             r_overflow;

  s2p_shift_cnt #(
    .WIDTH (WIDTH)
  ) u_shift_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_enable    (i_enable),
    .i_bit       (i_S2P),
    .i_resync    (i_resync),
    .i_locked    (r_state == LOCKED),
    .o_sr_next   (w_sr_next),
    .o_fill_ok   (w_fill_ok),
    .o_word_done (w_word_done)
  );

  // State and word-count registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= HUNT;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  // Next state, word counting and load/drop decisions; resync beats everything.
  always_comb begin
    w_state_next    = r_state;
    w_word_cnt_next = r_word_cnt;
    w_load          = 1'b0;
    w_ovf_set       = 1'b0;
    if (i_resync) begin
      w_state_next    = HUNT;
      w_word_cnt_next = '0;
    end else begin
      case (r_state)
        HUNT: begin
          w_word_cnt_next = '0;
          if (i_enable && w_fill_ok && (w_sr_next == SYNC_WORD)) begin
            w_state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (w_word_done) begin
            if (!r_valid || bus.i_ready) begin
              w_load = 1'b1;
            end else begin
              w_ovf_set = 1'b1;
            end
            if (r_word_cnt == c_LAST_WORD) begin
              w_state_next    = HUNT;
              w_word_cnt_next = '0;
            end else begin
              w_word_cnt_next = r_word_cnt + 8'd1;
            end
          end
        end
        default: begin
          w_state_next    = HUNT;
          w_word_cnt_next = '0;
        end
      endcase
    end
  end

  // Output slot: load a finished word, or retire the held one when accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_sr_next;
      r_valid <= 1'b1;
      r_sof   <= (r_word_cnt == 8'd0);
    end else if (r_valid && bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overflow; a new drop wins over a clear on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_sof   = r_sof;
  assign o_locked    = (r_state == LOCKED);
  assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_s2p_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_s2p_deframer                                           |
// | Purpose  : Self-checking bench for s2p_deframer: directed framing    |
// |            scenarios plus randomized traffic against a bit-level     |
// |            behavioural reference.                                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_s2p_deframer;
  import s2p_pkg::*;

  localparam int          W    = 16;
  localparam logic [15:0] SYNC = 16'hCCCC;
  localparam int          FW   = 4;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic s2p     = 1'b0;
  logic enable  = 1'b0;
  logic resync  = 1'b0;
  logic clr_ovf = 1'b0;
  logic locked;
  logic overflow;

  int checks = 0;
  int errors = 0;

  s2p_deframer_if #(.WIDTH(W)) bus ();

  s2p_deframer #(
    .WIDTH       (W),
    .SYNC_WORD   (SYNC),
    .FRAME_WORDS (FW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_S2P      (s2p),
    .i_enable   (enable),
    .i_resync   (resync),
    .i_clr_ovf  (clr_ovf),
    .bus        (bus),
    .o_locked   (locked),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_hunt;
  int          m_window;
  logic [15:0] m_sr;
  int          m_bits;
  int          m_words;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_sof;
  logic        m_ovf;

  task model_reset();
    m_hunt = 1'b1; m_window = 0; m_sr = '0; m_bits = 0; m_words = 0;
    m_data = '0; m_valid = 1'b0; m_sof = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock edge of the framing rules, applied to the inputs seen at that edge.
  task model_step();
    bit consumed, loaded, dropped;
    consumed = m_valid && bus.i_ready;
    loaded   = 1'b0;
    dropped  = 1'b0;
    if (resync) begin
      m_hunt = 1'b1; m_window = 0; m_bits = 0; m_words = 0;
    end else if (enable) begin
      m_sr = {m_sr[14:0], s2p};
      if (m_hunt) begin
        m_window++;
        if (m_window >= W && m_sr == SYNC) begin
          m_hunt = 1'b0; m_bits = 0; m_words = 0;
        end
      end else begin
        m_bits++;
        if (m_bits == W) begin
          m_bits = 0;
          if (!m_valid || consumed) begin
            m_data = m_sr; m_sof = (m_words == 0); loaded = 1'b1;
          end else begin
            dropped = 1'b1;
          end
          m_words++;
          if (m_words == FW) begin
            m_hunt = 1'b1; m_window = 0;
          end
        end
      end
    end
    if (loaded) m_valid = 1'b1;
    else if (consumed) m_valid = 1'b0;
    if (dropped) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  always @(negedge rst_n) model_reset();
  always @(posedge clk) if (rst_n) model_step();

  task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, shortly after each edge.
  always @(posedge clk) begin
    #2;
    chk("cyc_valid",    32'(bus.o_valid), 32'(m_valid));
    chk("cyc_data",     32'(bus.o_data),  32'(m_data));
    chk("cyc_sof",      32'(bus.o_sof),   32'(m_sof));
    chk("cyc_locked",   32'(locked),      32'(!m_hunt));
    chk("cyc_overflow", 32'(overflow),    32'(m_ovf));
  end

  // Record every word the consumer takes, just before the accepting edge.
  logic [16:0] cap[$];
  logic [16:0] exp_q[$];
  always @(posedge clk) begin
    #8;
    if (rst_n && bus.o_valid && bus.i_ready) cap.push_back({bus.o_sof, bus.o_data});
  end

  task expect_cap(input string nm);
    chk({nm, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap.size()) chk({nm, "_word"}, 32'(cap[i]), 32'(exp_q[i]));
    end
    cap.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task tick();
    @(posedge clk);
    #4;
  endtask

  task send_word(input logic [15:0] w, input bit gap);
    for (int i = 15; i >= 0; i--) begin
      s2p = w[i]; enable = 1'b1;
      tick();
      if (gap) begin
        enable = 1'b0; s2p = 1'($urandom);
        tick();
      end
    end
    enable = 1'b0;
  endtask

  task do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid",    32'(bus.o_valid), 32'd0);
    chk("rst_data",     32'(bus.o_data),  32'd0);
    chk("rst_sof",      32'(bus.o_sof),   32'd0);
    chk("rst_locked",   32'(locked),      32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    enable = 1'b0; resync = 1'b0; clr_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_locked_after", 32'(locked), 32'd0);
    cap.delete();
    exp_q.delete();
  endtask

  logic [15:0] frame[5];
  logic        bq[$];
  logic [15:0] rw;

  initial begin
    model_reset();
    bus.i_ready = 1'b0;
    frame[0] = 16'hCCCC; frame[1] = 16'h1234; frame[2] = 16'hABCD;
    frame[3] = 16'h0F0F; frame[4] = 16'h8001;
    tick();
    do_reset();

    // Lock and full frame, consumer always ready.
    bus.i_ready = 1'b1;
    send_word(frame[0], 1'b0);
    chk("lock_at_bit16", 32'(locked), 32'd1);
    send_word(frame[1], 1'b0);
    chk("w1_valid", 32'(bus.o_valid), 32'd1);
    chk("w1_data",  32'(bus.o_data),  32'h1234);
    chk("w1_sof",   32'(bus.o_sof),   32'd1);
    for (int k = 2; k < 5; k++) send_word(frame[k], 1'b0);
    chk("unlock_end_frame", 32'(locked), 32'd0);
    tick();
    exp_q = '{17'h11234, 17'h0ABCD, 17'h00F0F, 17'h08001};
    expect_cap("frame");

    // Same frame with an idle cycle after every bit.
    for (int k = 0; k < 5; k++) send_word(frame[k], 1'b1);
    tick();
    exp_q = '{17'h11234, 17'h0ABCD, 17'h00F0F, 17'h08001};
    expect_cap("gaps");

    // Consumer stalled for the whole frame.
    bus.i_ready = 1'b0;
    send_word(frame[0], 1'b0);
    send_word(frame[1], 1'b0);
    chk("stall_no_ovf_yet", 32'(overflow), 32'd0);
    send_word(frame[2], 1'b0);
    chk("stall_ovf_word2", 32'(overflow), 32'd1);
    send_word(frame[3], 1'b0);
    send_word(frame[4], 1'b0);
    chk("stall_data_held", 32'(bus.o_data), 32'h1234);
    chk("stall_sof_held",  32'(bus.o_sof),  32'd1);
    bus.i_ready = 1'b1;
    tick();
    chk("stall_released", 32'(bus.o_valid), 32'd0);
    chk("stall_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    exp_q = '{17'h11234};
    expect_cap("stall");

    // Reset in the middle of a frame with a word pending.
    bus.i_ready = 1'b0;
    send_word(frame[0], 1'b0);
    send_word(frame[1], 1'b0);
    do_reset();

    // Continuous sync pattern: payload of sync words, then relock.
    bus.i_ready = 1'b1;
    send_word(SYNC, 1'b0);
    chk("cc_lock", 32'(locked), 32'd1);
    for (int k = 0; k < 4; k++) send_word(SYNC, 1'b0);
    chk("cc_unlock", 32'(locked), 32'd0);
    send_word(SYNC, 1'b0);
    chk("cc_relock", 32'(locked), 32'd1);
    for (int k = 0; k < 4; k++) send_word(SYNC, 1'b0);
    tick();
    exp_q = '{17'h1CCCC, 17'h0CCCC, 17'h0CCCC, 17'h0CCCC,
              17'h1CCCC, 17'h0CCCC, 17'h0CCCC, 17'h0CCCC};
    expect_cap("ccframe");

    // Resync partway through payload word 2.
    do_reset();
    bus.i_ready = 1'b1;
    send_word(frame[0], 1'b0);
    send_word(frame[1], 1'b0);
    for (int i = 15; i >= 9; i--) begin
      s2p = frame[2][i]; enable = 1'b1;
      tick();
    end
    s2p = frame[2][8]; resync = 1'b1;
    tick();
    resync = 1'b0; enable = 1'b0;
    chk("resync_unlock", 32'(locked), 32'd0);
    send_word(SYNC, 1'b0);
    chk("resync_relock", 32'(locked), 32'd1);
    send_word(16'h5555, 1'b0);
    tick();
    exp_q = '{17'h11234, 17'h15555};
    expect_cap("resync");

    // Randomized traffic, checked every cycle against the model.
    do_reset();
    for (int n = 0; n < 6000; n++) begin
      if (bq.size() == 0) begin
        rw = ($urandom_range(0, 1) == 0) ? SYNC : 16'($urandom);
        for (int i = 15; i >= 0; i--) bq.push_back(rw[i]);
      end
      enable = ($urandom_range(0, 3) != 0);
      if (enable) s2p = bq.pop_front();
      else s2p = 1'($urandom);
      bus.i_ready = ((n / 200) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                         : ($urandom_range(0, 2) != 0);
      resync  = ($urandom_range(0, 399) == 0);
      clr_ovf = ($urandom_range(0, 59) == 0);
      tick();
    end
    enable = 1'b0; resync = 1'b0; clr_ovf = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
